// File: rtl/page_allocator.sv
// Free-page manager for the shared packet SRAM: a circular free-list of page
// addresses, loaded with every page after reset, handing out one page per cycle.
module page_allocator #(
  parameter int address_width   = 12,
  parameter int num_pages       = 4096,
  parameter int almost_empty_th = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  output logic                     alloc_rdy,
  input  logic                     alloc_req,
  output logic                     alloc_vld,
  output logic [address_width-1:0] alloc_addr,
  input  logic                     free_req,
  input  logic [address_width-1:0] free_addr,
  output logic [address_width:0]   free_cnt,
  output logic                     alloc_almost_empty,
  output logic                     free_err
);

  localparam int CW = address_width + 1;
  localparam logic [CW-1:0]            C_NUM  = CW'(num_pages);
  localparam logic [CW-1:0]            C_TH   = CW'(almost_empty_th);
  localparam logic [address_width-1:0] C_LAST = address_width'(num_pages - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                   r_state;
  logic [address_width-1:0] r_rd_ptr;
  logic [address_width-1:0] r_wr_ptr;
  logic [CW-1:0]            r_free_cnt;
  logic                     r_init_done;
  logic                     r_alloc_vld;
  logic                     r_free_err;
  logic                     r_almost_empty;
  logic                     r_addr_seen;
  logic [address_width-1:0] r_rd_data;
  logic [address_width-1:0] r_list [num_pages];

  logic                     w_run;
  logic                     w_full;
  logic                     w_grant;
  logic                     w_free_ok;
  logic                     w_free_drop;
  logic                     w_init_wr;
  logic                     w_wr_en;
  logic [address_width-1:0] w_wr_data;
  logic [address_width-1:0] w_wr_ptr_inc;
  logic [address_width-1:0] w_rd_ptr_inc;
  logic [CW-1:0]            w_cnt_next;

  assign w_run       = (r_state == S_RUN);
  assign w_full      = (r_free_cnt == C_NUM);
  assign w_grant     = w_run && alloc_req && (r_free_cnt != '0);
  // A full list can still take a page back when a grant frees a slot the same edge.
  assign w_free_ok   = w_run && free_req && (!w_full || w_grant);
  assign w_free_drop = w_run && free_req && w_full && !w_grant;
  // While loading, wr_ptr doubles as the init counter: list[n] = n.
  assign w_init_wr   = (r_state == S_INIT) && !w_full;
  assign w_wr_en     = w_init_wr || w_free_ok;
  assign w_wr_data   = w_run ? free_addr : r_wr_ptr;

  assign w_wr_ptr_inc = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;

  always_comb begin
    w_cnt_next = r_free_cnt;
    if (w_wr_en && !w_grant) begin
      w_cnt_next = r_free_cnt + 1'b1;
    end else if (!w_wr_en && w_grant) begin
      w_cnt_next = r_free_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_INIT;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_free_cnt     <= '0;
      r_init_done    <= 1'b0;
      r_alloc_vld    <= 1'b0;
      r_free_err     <= 1'b0;
      r_almost_empty <= 1'b0;
      r_addr_seen    <= 1'b0;
    end else begin
      r_free_cnt     <= w_cnt_next;
      r_almost_empty <= (w_cnt_next <= C_TH);
      r_alloc_vld    <= w_grant;
      r_free_err     <= w_free_drop;
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_grant) begin
        r_rd_ptr    <= w_rd_ptr_inc;
        r_addr_seen <= 1'b1;
      end
      case (r_state)
        S_INIT: begin
          if (w_full) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // RAM port kept free of reset so it maps onto block RAM; the read register
  // only loads on a grant, which makes alloc_addr hold between grants.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_list[r_wr_ptr] <= w_wr_data;
    end
    if (w_grant) begin
      r_rd_data <= r_list[r_rd_ptr];
    end
  end

  assign init_done          = r_init_done;
  assign alloc_rdy          = w_run && (r_free_cnt != '0);
  assign alloc_vld          = r_alloc_vld;
  assign alloc_addr         = r_addr_seen ? r_rd_data : '0;
  assign free_cnt           = r_free_cnt;
  assign alloc_almost_empty = r_almost_empty;
  assign free_err           = r_free_err;

endmodule

// File: tb/tb_page_allocator.sv
// Bench for page_allocator: two instances (8 and 32 pages) each checked every
// cycle against a queue-based free-list model, plus directed literal checks.
`timescale 1ns/1ps
module tb_page_allocator;

  localparam int AW = 6;
  localparam int TH = 16;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_w        [2];
  logic          alloc_req_w  [2];
  logic          free_req_w   [2];
  logic [AW-1:0] free_addr_w  [2];
  logic          init_done_w  [2];
  logic          alloc_rdy_w  [2];
  logic          alloc_vld_w  [2];
  logic [AW-1:0] alloc_addr_w [2];
  logic [AW:0]   free_cnt_w   [2];
  logic          ae_w         [2];
  logic          free_err_w   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int exp_seq [5] = '{6, 7, 3, 1, 4};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int NP = (gi == 0) ? 8 : 32;
    logic l_rst;
    assign l_rst = rst_w[gi];

    page_allocator #(
      .address_width(AW), .num_pages(NP), .almost_empty_th(TH)
    ) u_dut (
      .clk(clk), .rst(rst_w[gi]),
      .init_done(init_done_w[gi]), .alloc_rdy(alloc_rdy_w[gi]),
      .alloc_req(alloc_req_w[gi]), .alloc_vld(alloc_vld_w[gi]),
      .alloc_addr(alloc_addr_w[gi]), .free_req(free_req_w[gi]),
      .free_addr(free_addr_w[gi]), .free_cnt(free_cnt_w[gi]),
      .alloc_almost_empty(ae_w[gi]), .free_err(free_err_w[gi])
    );

    // Model: the free pool is a FIFO queue of addresses.
    logic [AW-1:0] m_q [$];
    int            m_edges = 0;
    int            m_cnt   = 0;
    bit            m_done  = 0;
    bit            m_vld   = 0;
    bit            m_err   = 0;
    bit            m_ae    = 0;
    logic [AW-1:0] m_addr  = '0;

    always @(posedge clk or negedge l_rst) begin
      if (!l_rst) begin
        m_q.delete();
        m_edges = 0; m_cnt = 0; m_done = 0;
        m_vld = 0; m_err = 0; m_ae = 0; m_addr = '0;
      end else if (!m_done) begin
        if (m_edges == NP) begin
          m_done = 1;
          for (int i = 0; i < NP; i++) m_q.push_back(AW'(i));
        end else begin
          m_cnt = m_edges + 1;
        end
        m_edges++;
        m_ae = (m_cnt <= TH);
      end else begin : run_step
        bit g;
        bit full;
        g     = alloc_req_w[gi] && (m_q.size() != 0);
        full  = (m_q.size() == NP);
        m_err = free_req_w[gi] && full && !g;
        m_vld = g;
        if (g) m_addr = m_q.pop_front();
        if (free_req_w[gi] && (!full || g)) m_q.push_back(free_addr_w[gi]);
        m_cnt = m_q.size();
        m_ae  = (m_cnt <= TH);
      end
    end

    always @(negedge clk) begin
      check($sformatf("d%0d init_done", gi), int'(init_done_w[gi]), int'(m_done));
      check($sformatf("d%0d alloc_rdy", gi), int'(alloc_rdy_w[gi]),
            int'(m_done && (m_q.size() != 0)));
      check($sformatf("d%0d alloc_vld", gi), int'(alloc_vld_w[gi]), int'(m_vld));
      check($sformatf("d%0d alloc_addr", gi), int'(alloc_addr_w[gi]), int'(m_addr));
      check($sformatf("d%0d free_cnt", gi), int'(free_cnt_w[gi]), m_cnt);
      check($sformatf("d%0d almost_empty", gi), int'(ae_w[gi]), int'(m_ae));
      check($sformatf("d%0d free_err", gi), int'(free_err_w[gi]), int'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_w[d] = 1'b0; alloc_req_w[d] = 1'b0;
      free_req_w[d] = 1'b0; free_addr_w[d] = '0;
    end
    repeat (2) cyc();
    for (int d = 0; d < 2; d++) begin
      check("reset init_done", int'(init_done_w[d]), 0);
      check("reset free_cnt", int'(free_cnt_w[d]), 0);
      check("reset alloc_rdy", int'(alloc_rdy_w[d]), 0);
    end

    // Release: next edge is the first with rst=1.
    rst_w[0] = 1'b1; rst_w[1] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      cyc();
      check($sformatf("d0 init_done cycle %0d", k), int'(init_done_w[0]), (k == 8) ? 1 : 0);
    end
    check("d0 free_cnt after init", int'(free_cnt_w[0]), 8);
    check("d0 alloc_rdy after init", int'(alloc_rdy_w[0]), 1);

    // Drain: 9 requests, 8 grants.
    alloc_req_w[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      check($sformatf("d0 drain vld %0d", i), int'(alloc_vld_w[0]), (i < 8) ? 1 : 0);
      if (i < 8) check($sformatf("d0 drain addr %0d", i), int'(alloc_addr_w[0]), i);
    end
    check("d0 empty alloc_rdy", int'(alloc_rdy_w[0]), 0);
    check("d0 empty free_cnt", int'(free_cnt_w[0]), 0);

    // Empty list: free 5 while alloc held; no bypass.
    free_req_w[0] = 1'b1; free_addr_w[0] = 6'd5;
    cyc();
    free_req_w[0] = 1'b0;
    check("d0 empty+free cnt", int'(free_cnt_w[0]), 1);
    check("d0 empty+free no grant", int'(alloc_vld_w[0]), 0);
    cyc();
    alloc_req_w[0] = 1'b0;
    check("d0 regrant vld", int'(alloc_vld_w[0]), 1);
    check("d0 regrant addr", int'(alloc_addr_w[0]), 5);
    check("d0 regrant cnt", int'(free_cnt_w[0]), 0);

    // Refill to full, then overflow free.
    free_req_w[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      free_addr_w[0] = AW'(i);
      cyc();
    end
    free_addr_w[0] = 6'd3;
    cyc();
    check("d0 overflow free_err", int'(free_err_w[0]), 1);
    check("d0 overflow cnt", int'(free_cnt_w[0]), 8);
    alloc_req_w[0] = 1'b1;
    cyc();
    alloc_req_w[0] = 1'b0; free_req_w[0] = 1'b0;
    check("d0 full both vld", int'(alloc_vld_w[0]), 1);
    check("d0 full both addr", int'(alloc_addr_w[0]), 0);
    check("d0 full both err", int'(free_err_w[0]), 0);
    check("d0 full both cnt", int'(free_cnt_w[0]), 8);

    // Fresh list, then wrap-around sequence.
    rst_w[0] = 1'b0;
    #1;
    check("d0 async reset init_done", int'(init_done_w[0]), 0);
    check("d0 async reset cnt", int'(free_cnt_w[0]), 0);
    cyc();
    rst_w[0] = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    check("d0 reinit done", int'(init_done_w[0]), 1);
    alloc_req_w[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    alloc_req_w[0] = 1'b0;
    check("d0 after 6 allocs cnt", int'(free_cnt_w[0]), 2);
    free_req_w[0] = 1'b1;
    free_addr_w[0] = 6'd3; cyc();
    free_addr_w[0] = 6'd1; cyc();
    free_addr_w[0] = 6'd4; cyc();
    free_req_w[0] = 1'b0;
    alloc_req_w[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("d0 wrap vld %0d", i), int'(alloc_vld_w[0]), 1);
      check($sformatf("d0 wrap addr %0d", i), int'(alloc_addr_w[0]), exp_seq[i]);
    end
    alloc_req_w[0] = 1'b0;

    // 32-page instance: almost-empty threshold.
    check("d1 init_done", int'(init_done_w[1]), 1);
    check("d1 full cnt", int'(free_cnt_w[1]), 32);
    check("d1 full ae", int'(ae_w[1]), 0);
    alloc_req_w[1] = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    alloc_req_w[1] = 1'b0;
    check("d1 cnt 17", int'(free_cnt_w[1]), 17);
    check("d1 ae at 17", int'(ae_w[1]), 0);
    alloc_req_w[1] = 1'b1;
    cyc();
    alloc_req_w[1] = 1'b0;
    check("d1 cnt 16", int'(free_cnt_w[1]), 16);
    check("d1 ae at 16", int'(ae_w[1]), 1);
    free_req_w[1] = 1'b1; free_addr_w[1] = 6'd9;
    cyc();
    free_req_w[1] = 1'b0;
    check("d1 cnt back 17", int'(free_cnt_w[1]), 17);
    check("d1 ae back 0", int'(ae_w[1]), 0);

    // Reset mid-run with a request pending.
    alloc_req_w[1] = 1'b1;
    #1;
    rst_w[1] = 1'b0;
    #1;
    check("d1 midrun reset init_done", int'(init_done_w[1]), 0);
    check("d1 midrun reset cnt", int'(free_cnt_w[1]), 0);
    check("d1 midrun reset rdy", int'(alloc_rdy_w[1]), 0);
    check("d1 midrun reset ae", int'(ae_w[1]), 0);
    check("d1 midrun reset addr", int'(alloc_addr_w[1]), 0);
    cyc();
    check("d1 no partial grant", int'(alloc_vld_w[1]), 0);
    alloc_req_w[1] = 1'b0;
    rst_w[1] = 1'b1;
    cyc();
    check("d1 restart done low", int'(init_done_w[1]), 0);
    check("d1 restart cnt 1", int'(free_cnt_w[1]), 1);
    repeat (40) cyc();
    check("d1 restart done", int'(init_done_w[1]), 1);
    check("d1 restart cnt", int'(free_cnt_w[1]), 32);

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
